// File: rtl/pc_ras_if.sv
// pc_ras_if: control strobes from the decoder and PC/RAS status towards fetch.
interface pc_ras_if #(
   parameter int unsigned PC_W   = 16,
   parameter int unsigned DISP_W = 8
);
   logic              pcEn;
   logic              branch;
   logic              jump;
   logic              call;
   logic              ret;
   logic              clrErr;
   logic [DISP_W-1:0] disp;
   logic [PC_W-1:0]   dSrc;
   logic [PC_W-1:0]   pc;
   logic [PC_W-1:0]   ra;
   logic              rasEmpty;
   logic              rasFull;
   logic              rasOvf;
   logic              rasUnf;

   modport master (
      output pcEn, branch, jump, call, ret, clrErr, disp, dSrc,
      input  pc, ra, rasEmpty, rasFull, rasOvf, rasUnf
   );

   modport slave (
      input  pcEn, branch, jump, call, ret, clrErr, disp, dSrc,
      output pc, ra, rasEmpty, rasFull, rasOvf, rasUnf
   );
endinterface

// File: rtl/pc_ras.sv
// pc_ras: fetch-stage program counter with a circular return-address stack.
// Build option: define PC_RAS_EN to compile in the RAS; without it call/ret
// act as jumps to dSrc and the stack status outputs are tied off.
module pc_ras #(
   parameter int unsigned     PC_W      = 16,
   parameter int unsigned     DISP_W    = 8,
   parameter int unsigned     RAS_DEPTH = 4,
   parameter logic [PC_W-1:0] RESET_PC  = '0
) (
   input logic     clk,
   input logic     rst,
   pc_ras_if.slave bus
);
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] pc_inc, pc_br;

   // Sequential and PC-relative candidates; both wrap modulo 2^PC_W.
   assign pc_inc = pc_q + PC_W'(1);
   assign pc_br  = pc_q + PC_W'($signed(bus.disp));

   // PC register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) pc_q <= RESET_PC;
      else      pc_q <= pc_d;
   end

   assign bus.pc = pc_q;

`ifdef PC_RAS_EN
   localparam int unsigned     PTR_W    = $clog2(RAS_DEPTH);
   localparam int unsigned     CNT_W    = $clog2(RAS_DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

   logic [PC_W-1:0]  stack_q [RAS_DEPTH];
   logic [PTR_W-1:0] top_q, top_d;
   logic [CNT_W-1:0] depth_q, depth_d;
   logic [PC_W-1:0]  ra_q, ra_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic             empty_q, full_q;
   logic             push;

   // Next PC by priority ret > call > jump > branch > increment, plus stack update.
   always_comb begin
      pc_d    = pc_q;
      top_d   = top_q;
      depth_d = depth_q;
      ra_d    = ra_q;
      push    = 1'b0;
      ovf_d   = ovf_q & ~bus.clrErr;
      unf_d   = unf_q & ~bus.clrErr;
      if (bus.pcEn) begin
         if (bus.ret) begin
            if (depth_q != '0) begin
               pc_d    = stack_q[top_q];
               top_d   = top_q - PTR_W'(1);
               depth_d = depth_q - CNT_W'(1);
               ra_d    = (depth_q > CNT_W'(1)) ? stack_q[top_q - PTR_W'(1)] : '0;
            end else begin
               pc_d  = bus.dSrc;
               unf_d = 1'b1;
            end
         end else if (bus.call) begin
            // Full stack: advancing top overwrites the oldest entry.
            pc_d  = bus.dSrc;
            push  = 1'b1;
            top_d = top_q + PTR_W'(1);
            ra_d  = pc_inc;
            if (depth_q == FULL_CNT) ovf_d   = 1'b1;
            else                     depth_d = depth_q + CNT_W'(1);
         end else if (bus.jump) begin
            pc_d = bus.dSrc;
         end else if (bus.branch) begin
            pc_d = pc_br;
         end else begin
            pc_d = pc_inc;
         end
      end
   end

   // Stack bookkeeping, registered top-of-stack copy and status flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         top_q   <= '0;
         depth_q <= '0;
         ra_q    <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
      end else begin
         top_q   <= top_d;
         depth_q <= depth_d;
         ra_q    <= ra_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         empty_q <= (depth_d == '0);
         full_q  <= (depth_d == FULL_CNT);
      end
   end

   // Return-address storage; contents are meaningless while depth is 0.
   always_ff @(posedge clk) begin
      if (push) stack_q[top_d] <= pc_inc;
   end

   assign bus.ra       = ra_q;
   assign bus.rasEmpty = empty_q;
   assign bus.rasFull  = full_q;
   assign bus.rasOvf   = ovf_q;
   assign bus.rasUnf   = unf_q;
`else
   logic unused_clr;

   // Next PC: call and ret degrade to absolute jumps.
   always_comb begin
      pc_d = pc_q;
      if (bus.pcEn) begin
         if (bus.ret || bus.call || bus.jump) pc_d = bus.dSrc;
         else if (bus.branch)                 pc_d = pc_br;
         else                                 pc_d = pc_inc;
      end
   end

   assign unused_clr   = bus.clrErr;
   assign bus.ra       = '0;
   assign bus.rasEmpty = 1'b1;
   assign bus.rasFull  = 1'b0;
   assign bus.rasOvf   = 1'b0;
   assign bus.rasUnf   = 1'b0;
`endif
endmodule

// File: tb/tb_pc_ras.sv
// tb_pc_ras: directed table plus randomized run against a queue-based model.
module tb_pc_ras;
   localparam int unsigned PC_W   = 16;
   localparam int unsigned DISP_W = 8;
   localparam int unsigned DEPTH  = 4;
`ifdef PC_RAS_EN
   localparam bit RAS_EN = 1'b1;
`else
   localparam bit RAS_EN = 1'b0;
`endif

   logic clk;
   logic rst;

   pc_ras_if #(.PC_W(PC_W), .DISP_W(DISP_W)) bus ();

   pc_ras #(
      .PC_W(PC_W), .DISP_W(DISP_W), .RAS_DEPTH(DEPTH), .RESET_PC(16'h0000)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ctl = {en, branch, jump, call, ret, clrErr}; flg = {empty, full, ovf, unf}
   typedef struct {
      logic [5:0]  ctl;
      logic [7:0]  disp;
      logic [15:0] dsrc;
      logic [15:0] pc_r;
      logic [15:0] pc_n;
      logic [15:0] ra;
      logic [3:0]  flg;
   } vec_t;

   int checks   = 0;
   int failures = 0;

   int m_pc;
   int m_stk[$];
   bit m_ovf;
   bit m_unf;

   function automatic vec_t mk(input logic [5:0] ctl, input logic [7:0] disp,
                               input logic [15:0] dsrc, pc_r, pc_n, ra,
                               input logic [3:0] flg);
      vec_t v;
      v.ctl = ctl; v.disp = disp; v.dsrc = dsrc;
      v.pc_r = pc_r; v.pc_n = pc_n; v.ra = ra; v.flg = flg;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s[%0d] got=%h expected=%h", name, idx, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input int idx, input logic [15:0] epc,
                            input logic [15:0] era, input logic [3:0] eflg);
      chk({tag, ".pc"}, idx, 32'(bus.pc), 32'(epc));
      chk({tag, ".ra"}, idx, 32'(bus.ra), 32'(era));
      chk({tag, ".rasEmpty"}, idx, 32'(bus.rasEmpty), 32'(eflg[3]));
      chk({tag, ".rasFull"}, idx, 32'(bus.rasFull), 32'(eflg[2]));
      chk({tag, ".rasOvf"}, idx, 32'(bus.rasOvf), 32'(eflg[1]));
      chk({tag, ".rasUnf"}, idx, 32'(bus.rasUnf), 32'(eflg[0]));
   endtask

   task automatic apply(input vec_t v);
      bus.pcEn   = v.ctl[5];
      bus.branch = v.ctl[4];
      bus.jump   = v.ctl[3];
      bus.call   = v.ctl[2];
      bus.ret    = v.ctl[1];
      bus.clrErr = v.ctl[0];
      bus.disp   = v.disp;
      bus.dSrc   = v.dsrc;
   endtask

   task automatic model_reset();
      m_pc = 0;
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   // Architectural effect of one enabled/disabled edge.
   task automatic model_step(input vec_t v);
      bit set_o;
      bit set_u;
      int d;
      set_o = 1'b0;
      set_u = 1'b0;
      d = (v.disp >= 8'h80) ? int'(v.disp) - 256 : int'(v.disp);
      if (v.ctl[5]) begin
         if (RAS_EN && v.ctl[1]) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin
               m_pc  = int'(v.dsrc);
               set_u = 1'b1;
            end
         end else if (RAS_EN && v.ctl[2]) begin
            if (m_stk.size() == DEPTH) begin
               void'(m_stk.pop_front());
               set_o = 1'b1;
            end
            m_stk.push_back((m_pc + 1) & 32'h0000FFFF);
            m_pc = int'(v.dsrc);
         end else if (v.ctl[1] || v.ctl[2] || v.ctl[3]) begin
            m_pc = int'(v.dsrc);
         end else if (v.ctl[4]) begin
            m_pc = (m_pc + d) & 32'h0000FFFF;
         end else begin
            m_pc = (m_pc + 1) & 32'h0000FFFF;
         end
      end
      if (v.ctl[0]) begin
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end
      if (set_o) m_ovf = 1'b1;
      if (set_u) m_unf = 1'b1;
   endtask

   task automatic check_model(input string tag, input int idx);
      logic [15:0] era;
      logic [3:0]  eflg;
      era  = (m_stk.size() > 0) ? 16'(m_stk[$]) : 16'h0000;
      eflg = {m_stk.size() == 0, m_stk.size() == DEPTH, m_ovf, m_unf};
      check_all(tag, idx, 16'(m_pc), era, eflg);
   endtask

   task automatic step_model(input string tag, input int idx, input vec_t v);
      apply(v);
      @(posedge clk);
      model_step(v);
      #1;
      check_model(tag, idx);
   endtask

   // Reset pulse placed between clock edges; state must clear immediately.
   task automatic async_reset(input string tag);
      #2 rst = 1'b0;
      #1 check_all(tag, 0, 16'h0000, 16'h0000, 4'b1000);
      model_reset();
      #1 rst = 1'b1;
   endtask

   function automatic vec_t rnd_vec();
      vec_t v;
      int r;
      r = $urandom_range(0, 99);
      v = mk(6'b0, 8'($urandom), 16'($urandom), 16'h0, 16'h0, 16'h0, 4'h0);
      v.ctl[5] = ($urandom_range(0, 9) != 0);
      v.ctl[4] = (r >= 50 && r < 85);
      v.ctl[3] = (r >= 45 && r < 55);
      v.ctl[2] = (r >= 20 && r < 50);
      v.ctl[1] = (r < 25);
      v.ctl[0] = ($urandom_range(0, 19) == 0);
      return v;
   endfunction

   vec_t tbl[$];

   initial begin
      // ctl                disp   dSrc      pc(RAS)   pc(noRAS) ra        flags
      tbl.push_back(mk(6'b100000, 8'h00, 16'h0000, 16'h0001, 16'h0001, 16'h0000, 4'b1000));
      tbl.push_back(mk(6'b100000, 8'h00, 16'h0000, 16'h0002, 16'h0002, 16'h0000, 4'b1000));
      tbl.push_back(mk(6'b100000, 8'h00, 16'h0000, 16'h0003, 16'h0003, 16'h0000, 4'b1000));
      tbl.push_back(mk(6'b000000, 8'h00, 16'h0000, 16'h0003, 16'h0003, 16'h0000, 4'b1000));
      tbl.push_back(mk(6'b000000, 8'h00, 16'h0000, 16'h0003, 16'h0003, 16'h0000, 4'b1000));
      tbl.push_back(mk(6'b110000, 8'h7F, 16'h0000, 16'h0082, 16'h0082, 16'h0000, 4'b1000));
      tbl.push_back(mk(6'b110000, 8'h80, 16'h0000, 16'h0002, 16'h0002, 16'h0000, 4'b1000));
      tbl.push_back(mk(6'b101000, 8'h00, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b1000));
      tbl.push_back(mk(6'b100000, 8'h00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b1000));
      tbl.push_back(mk(6'b101000, 8'h00, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b1000));
      tbl.push_back(mk(6'b110000, 8'h01, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b1000));
      tbl.push_back(mk(6'b101000, 8'h00, 16'h0010, 16'h0010, 16'h0010, 16'h0000, 4'b1000));
      tbl.push_back(mk(6'b100100, 8'h00, 16'h0100, 16'h0100, 16'h0100, 16'h0011, 4'b0000));
      tbl.push_back(mk(6'b100100, 8'h00, 16'h0200, 16'h0200, 16'h0200, 16'h0101, 4'b0000));
      tbl.push_back(mk(6'b100010, 8'h00, 16'h0777, 16'h0101, 16'h0777, 16'h0011, 4'b0000));
      tbl.push_back(mk(6'b100010, 8'h00, 16'h0888, 16'h0011, 16'h0888, 16'h0000, 4'b1000));
      tbl.push_back(mk(6'b101000, 8'h00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b1000));
      tbl.push_back(mk(6'b100100, 8'h00, 16'h0010, 16'h0010, 16'h0010, 16'h0001, 4'b0000));
      tbl.push_back(mk(6'b100100, 8'h00, 16'h0020, 16'h0020, 16'h0020, 16'h0011, 4'b0000));
      tbl.push_back(mk(6'b100100, 8'h00, 16'h0030, 16'h0030, 16'h0030, 16'h0021, 4'b0000));
      tbl.push_back(mk(6'b100100, 8'h00, 16'h0040, 16'h0040, 16'h0040, 16'h0031, 4'b0100));
      tbl.push_back(mk(6'b100100, 8'h00, 16'h0050, 16'h0050, 16'h0050, 16'h0041, 4'b0110));
      tbl.push_back(mk(6'b100010, 8'h00, 16'h0900, 16'h0041, 16'h0900, 16'h0031, 4'b0010));
      tbl.push_back(mk(6'b100010, 8'h00, 16'h0901, 16'h0031, 16'h0901, 16'h0021, 4'b0010));
      tbl.push_back(mk(6'b100010, 8'h00, 16'h0902, 16'h0021, 16'h0902, 16'h0011, 4'b0010));
      tbl.push_back(mk(6'b100010, 8'h00, 16'h0903, 16'h0011, 16'h0903, 16'h0000, 4'b1010));
      tbl.push_back(mk(6'b100010, 8'h00, 16'h0300, 16'h0300, 16'h0300, 16'h0000, 4'b1011));
      tbl.push_back(mk(6'b000011, 8'h00, 16'h0555, 16'h0300, 16'h0300, 16'h0000, 4'b1000));
      tbl.push_back(mk(6'b101000, 8'h00, 16'h0010, 16'h0010, 16'h0010, 16'h0000, 4'b1000));
      tbl.push_back(mk(6'b100100, 8'h00, 16'h0050, 16'h0050, 16'h0050, 16'h0011, 4'b0000));
      tbl.push_back(mk(6'b100110, 8'h00, 16'h0060, 16'h0011, 16'h0060, 16'h0000, 4'b1000));
      tbl.push_back(mk(6'b000100, 8'h00, 16'h0070, 16'h0011, 16'h0060, 16'h0000, 4'b1000));
      tbl.push_back(mk(6'b100011, 8'h00, 16'h0123, 16'h0123, 16'h0123, 16'h0000, 4'b1001));
      tbl.push_back(mk(6'b000001, 8'h00, 16'h0000, 16'h0123, 16'h0123, 16'h0000, 4'b1000));
      tbl.push_back(mk(6'b111000, 8'h05, 16'h0200, 16'h0200, 16'h0200, 16'h0000, 4'b1000));
      tbl.push_back(mk(6'b110000, 8'hFB, 16'h0000, 16'h01FB, 16'h01FB, 16'h0000, 4'b1000));

      // Reset held across edges.
      rst = 1'b0;
      apply(mk(6'b100000, 8'h00, 16'h0000, 16'h0, 16'h0, 16'h0, 4'h0));
      repeat (2) @(posedge clk);
      #1;
      check_all("reset", 0, 16'h0000, 16'h0000, 4'b1000);
      rst = 1'b1;

      // Directed table.
      foreach (tbl[i]) begin
         logic [15:0] epc;
         logic [15:0] era;
         logic [3:0]  eflg;
         apply(tbl[i]);
         @(posedge clk);
         #1;
         epc  = RAS_EN ? tbl[i].pc_r : tbl[i].pc_n;
         era  = RAS_EN ? tbl[i].ra : 16'h0000;
         eflg = RAS_EN ? tbl[i].flg : 4'b1000;
         check_all("tbl", i, epc, era, eflg);
      end

      // Known architectural state after the table.
      model_reset();
      m_pc = 32'h01FB;

      // Depth 3, then asynchronous reset mid-cycle, then a normal first edge.
      step_model("pre_rst", 0, mk(6'b100100, 8'h00, 16'h0100, 16'h0, 16'h0, 16'h0, 4'h0));
      step_model("pre_rst", 1, mk(6'b100100, 8'h00, 16'h0200, 16'h0, 16'h0, 16'h0, 4'h0));
      step_model("pre_rst", 2, mk(6'b100100, 8'h00, 16'h0300, 16'h0, 16'h0, 16'h0, 4'h0));
      async_reset("async_rst");
      step_model("post_rst", 0, mk(6'b100000, 8'h00, 16'h0000, 16'h0, 16'h0, 16'h0, 4'h0));
      chk("post_rst.pc_abs", 0, 32'(bus.pc), 32'h0000_0001);

      // Back-to-back call then ret returns that call's pc+1.
      step_model("b2b", 0, mk(6'b100100, 8'h00, 16'h0400, 16'h0, 16'h0, 16'h0, 4'h0));
      step_model("b2b", 1, mk(6'b100010, 8'h00, 16'h0999, 16'h0, 16'h0, 16'h0, 4'h0));

      // Randomized run against the model.
      for (int i = 0; i < 600; i++) begin
         step_model("rnd", i, rnd_vec());
         if (i == 300) async_reset("rnd_rst");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pc_ras.md
# pc_ras

Parametrised program-counter unit with an integrated return-address stack (RAS), the next-generation replacement for the fixed 16-bit `pc` block in the fetch stage. It keeps the sequential, branch and jump behaviour of the current PC, generalises address and displacement widths, and adds hardware call/return with a configurable-depth stack, overflow/underflow flags and a stall-safe enable. It sits between the decoder/controller (which drives the control strobes) and instruction memory (which consumes `pc`).

## Interface
- `PC_W`, 16: PC and address width in bits.
- `DISP_W`, 8: branch displacement width in bits. `disp` is two's-complement. Requires `DISP_W <= PC_W`.
- `RAS_DEPTH`, 4: number of return-address entries. Must be a power of two, at least 2.
- `RESET_PC`, 0: value loaded into `pc` on reset.

- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `pcEn`  in  1  advance enable; when 0, all state holds.
- `branch`  in  1  PC-relative branch.
- `jump`  in  1  absolute jump to `dSrc`.
- `call`  in  1  jump to `dSrc` and push `pc+1`.
- `ret`  in  1  pop the top of the RAS into `pc`.
- `disp`  in  DISP_W  branch displacement.
- `dSrc`  in  PC_W  absolute target; also the fallback target for `ret` when the stack is empty.
- `clrErr`  in  1  synchronous clear of the sticky flags.
- `pc`  out  PC_W  current PC (registered).
- `ra`  out  PC_W  current top-of-stack entry (0 when the stack is empty).
- `rasEmpty`  out  1  stack holds no entries.
- `rasFull`  out  1  stack holds `RAS_DEPTH` entries.
- `rasOvf`  out  1  sticky: a call was made while the stack was full.
- `rasUnf`  out  1  sticky: a return was made while the stack was empty.

## Operation
- Reset (`rst`=0, asynchronous):
  - `pc`=`RESET_PC`, depth=0, `rasEmpty`=1, `rasFull`=0, `rasOvf`=0, `rasUnf`=0, `ra`=0.
  - Stack contents need not be cleared.
- When `pcEn`=1, the next PC is selected by priority `ret` > `call` > `jump` > `branch` > increment:
  - increment: `pc+1`.
  - branch: `pc + sext(disp)`.
  - jump: `dSrc`.
  - call: `dSrc`, and push `pc+1`.
  - ret, non-empty: pop the top entry into `pc`.
  - ret, empty: `pc`=`dSrc`, set `rasUnf`, depth stays 0.
- All PC arithmetic is modulo 2^PC_W and wraps silently.
- Lower-priority strobes asserted with a higher-priority one are ignored; only one stack operation occurs per cycle.
- Call while full:
  - The stack is circular: the oldest entry is overwritten and depth stays `RAS_DEPTH`.
  - `rasOvf` is set.
  - The new entry becomes the top.
- When `pcEn`=0, `pc`, the stack, the depth and the flags are unchanged. `clrErr` still acts.
- `clrErr`=1 clears both sticky flags on the next edge. If a new overflow or underflow occurs in the same cycle, set wins.
- Stack state: a top pointer plus a depth counter in the range 0..RAS_DEPTH. `rasEmpty` and `rasFull` are decoded from the registered depth.

## Timing
- `pc` updates one cycle after the strobes are sampled at the rising edge; there is no combinational path from the strobes to `pc`.
- `ra`, `rasEmpty` and `rasFull` reflect the post-edge state in the same cycle as the new `pc`.
- Back-to-back call/ret is supported every cycle. A ret in the cycle after a call returns that call's `pc+1`.
- Reset asserted mid-sequence takes effect immediately, regardless of `clk`. The first edge after deassertion behaves as a normal `pcEn` cycle.

## Configuration
- `PC_RAS_EN` defined: the full RAS is compiled in, as described above.
- `PC_RAS_EN` undefined: no stack storage is built.
  - `call` behaves as `jump`.
  - `ret` behaves as `jump` to `dSrc`.
  - `ra`=0, `rasEmpty`=1, `rasFull`=0, and `rasOvf`=`rasUnf`=0 permanently.

## Test plan
Defaults `PC_W`=16, `DISP_W`=8, `RAS_DEPTH`=4, `PC_RAS_EN` defined.
- Reset/increment: hold `rst`=0 -> `pc`=0x0000 and `rasEmpty`=1. Release with `pcEn`=1 for 3 cycles -> `pc`=0x0003. Drop `pcEn` for 2 cycles -> `pc` holds 0x0003.
- Branch sign: from `pc`=0x0003, branch `disp`=0x7F -> 0x0082. Then `disp`=0x80 -> 0x0002.
- Wrap: jump `dSrc`=0xFFFF, then increment -> 0x0000. Jump to 0xFFFF again, then branch `disp`=0x01 -> 0x0000.
- Nested call/ret: at 0x0010 call 0x0100, then call 0x0200 -> `ra`=0x0101. ret -> 0x0101. ret -> 0x0011 and `rasEmpty`=1.
- Overflow/underflow: from 0x0000, call 0x10, 0x20, 0x30, 0x40 -> `rasFull`=1. Call 0x50 -> `rasOvf`=1.
  - Rets -> 0x0041, 0x0031, 0x0021, 0x0011.
  - Further ret with `dSrc`=0x0300 -> `pc`=0x0300 and `rasUnf`=1.
  - `clrErr` clears both flags.
- Priority/reset: call and ret in the same cycle with 1 entry 0x0011 -> `pc`=0x0011 and no push. `pcEn`=0 with `call` -> no change. Async `rst` pulse with depth 3 -> depth 0 and `pc`=0x0000 before the next edge.
